// File: rtl/fifo_burst_reader_if.sv
// Stream, FIFO-read and command/status signals of the burst reader, grouped
// so the reader and its environment connect through one port.
interface fifo_burst_reader_if #(
  parameter int D_WIDTH   = 8,
  parameter int LEN_WIDTH = 8
);
  logic                 start;
  logic [LEN_WIDTH-1:0] burst_len;
  logic                 fifo_empty;
  logic                 fifo_rd_en;
  logic [D_WIDTH-1:0]   fifo_rd_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [D_WIDTH-1:0]   m_data;
  logic                 busy;
  logic                 done;
  logic [LEN_WIDTH-1:0] beats_left;

  modport master (
    input  start, burst_len, fifo_empty, fifo_rd_data, m_ready,
    output fifo_rd_en, m_valid, m_data, busy, done, beats_left
  );

  modport slave (
    output start, burst_len, fifo_empty, fifo_rd_data, m_ready,
    input  fifo_rd_en, m_valid, m_data, busy, done, beats_left
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Read-side burst consumer: drains burst_len words from a FIFO with one cycle
// of read latency and replays them on a valid/ready stream via a small buffer.
module fifo_burst_reader #(
  parameter int D_WIDTH    = 8,
  parameter int OBUF_DEPTH = 2,
  parameter int LEN_WIDTH  = 8
) (
  input logic           rd_clk,
  input logic           reset,
  fifo_burst_reader_if.master bus
);

  localparam int PTR_W = $clog2(OBUF_DEPTH);
  localparam int CNT_W = $clog2(OBUF_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OBUF_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(OBUF_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] issued_q, issued_d;
  logic [LEN_WIDTH-1:0] beats_q, beats_d;
  logic                 done_q, done_d;
  logic                 inflight_q;
  logic [CNT_W-1:0]     occ_q, occ_d;
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [D_WIDTH-1:0]   buf_q [OBUF_DEPTH];

  logic                 pop;
  logic                 push;
  logic                 rd_en;
  logic [CNT_W:0]       pending;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop  = (occ_q != '0) && bus.m_ready;
  assign push = inflight_q;

  // Counting the same-cycle pop as free space lets a 2-entry buffer stream
  // one word per cycle despite the read latency.
  assign pending = {1'b0, occ_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);

  assign rd_en = !reset && (state_q == RUN) && (issued_q < len_q) &&
                 !bus.fifo_empty && (pending < DEPTH_C);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    beats_d  = beats_q;
    done_d   = 1'b0;
    if (rd_en) issued_d = issued_q + LEN_WIDTH'(1);
    if (pop && (beats_q != '0)) beats_d = beats_q - LEN_WIDTH'(1);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.burst_len != '0) begin
            len_d    = bus.burst_len;
            issued_d = '0;
            beats_d  = bus.burst_len;
            state_d  = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (issued_d == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        // Finish once the last word has left the buffer and none is in flight.
        if (!inflight_q && (occ_d == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (push) tail_d = ptr_inc(tail_q);
    if (pop)  head_d = ptr_inc(head_q);
    if (push && !pop)      occ_d = occ_q + CNT_W'(1);
    else if (!push && pop) occ_d = occ_q - CNT_W'(1);
  end

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      beats_q    <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      occ_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      beats_q    <= beats_d;
      done_q     <= done_d;
      inflight_q <= rd_en;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (push) buf_q[tail_q] <= bus.fifo_rd_data;
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ_q != '0);
  assign bus.m_data     = buf_q[head_q];
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.beats_left = beats_q;

  push_room_a: assert property (@(posedge rd_clk) disable iff (reset)
    ({1'b0, occ_q} + (CNT_W + 1)'(inflight_q)) <= DEPTH_C);

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side consumer for the async FIFO; lives entirely in the rd_clk domain.
- On a start command it drains exactly burst_len words from the FIFO read port.
- It absorbs the one-cycle registered read latency of the FIFO memory and presents the words on a valid/ready stream through a small output buffer.
- It pulses done when the last word of the burst has been accepted downstream.

Parameters:
- D_WIDTH, 8, data word width; must match the FIFO d_width.
- OBUF_DEPTH, 2, output buffer entries; legal range 2..4.
- LEN_WIDTH, 8, width of burst_len and the beat counters.

Ports:
- rd_clk  input  1  read-domain clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle burst request; sampled only in IDLE.
- burst_len  input  LEN_WIDTH  word count, sampled with start.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO read enable.
- fifo_rd_data  input  D_WIDTH  FIFO read data; valid the cycle after fifo_rd_en.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accept.
- m_data  output  D_WIDTH  output word.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse at burst completion.
- beats_left  output  LEN_WIDTH  words not yet accepted downstream.

Behaviour:
- Reset: the following all read 0 on the cycle after reset is sampled high:
  - state=IDLE;
  - occupancy, inflight and issued count;
  - fifo_rd_en, m_valid, busy, done and beats_left.
- While reset is high, fifo_rd_en is forced to 0.
- State machine IDLE / RUN / DRAIN:
  - IDLE: on start with burst_len != 0, latch len, clear issued, set beats_left=len, and go to RUN.
  - IDLE: on start with burst_len == 0, pulse done on the next cycle and stay in IDLE.
  - start outside IDLE is ignored.
  - RUN: go to DRAIN in the cycle when the issued count reaches len.
  - DRAIN: when occupancy==0 and inflight==0, go to IDLE and pulse done (registered, exactly one cycle).
- pop = m_valid & m_ready.
- fifo_rd_en (combinational from registered state plus inputs) is high when all of the following hold:
  - state==RUN;
  - issued<len;
  - !fifo_empty;
  - (occupancy + inflight - pop) < OBUF_DEPTH.
- The pop term is required so that OBUF_DEPTH=2 sustains 1 word/cycle.
- Issued increments on every fifo_rd_en.
- inflight is fifo_rd_en registered by one cycle.
- When inflight=1, fifo_rd_data is written to the buffer tail that cycle.
- The output buffer is an in-order circular buffer:
  - m_data is the head entry;
  - m_valid = occupancy != 0.
- Push and pop in the same cycle keep occupancy unchanged, and data order is preserved.
- A push never occurs while occupancy+inflight would exceed OBUF_DEPTH; this is guaranteed by construction and is a verification assertion.
- m_valid/m_data handshake rules:
  - Once m_valid is asserted, m_valid and m_data hold stable until a pop.
  - m_valid never depends combinationally on m_ready.
- beats_left decrements by 1 on each pop and reaches 0 exactly when done fires.
- Latency: start to first fifo_rd_en is 1 cycle, provided the FIFO is non-empty. First fifo_rd_en to m_valid is 2 cycles (FIFO read latency + buffer write).
- FIFO empty mid-burst: reads stall in RUN with no timeout, and resume when fifo_empty falls.
- m_ready low: reads throttle once the buffer plus inflight is full. No word is lost or duplicated.
- Counter width: the issued count and beats_left use LEN_WIDTH bits. The maximum burst is 2^LEN_WIDTH-1 words, and no wrap-around is possible.
- Reset mid-burst: buffered and in-flight data are discarded, state goes to IDLE, and done is not pulsed.
- Words already popped from the FIFO are lost on reset; this is a system-level responsibility.

Test Plan:
- Reset then start, burst_len=4, FIFO preloaded with 0x11,0x22,0x33,0x44, m_ready=1:
  - fifo_rd_en is high for 4 consecutive cycles;
  - m_data sequence is 0x11,0x22,0x33,0x44 on consecutive cycles;
  - done pulses exactly once, the cycle after the last pop;
  - beats_left=0.
- burst_len=6 with m_ready toggling 1,0,0,1,…:
  - all 6 words arrive in order with no duplicates;
  - occupancy+inflight never exceeds 2;
  - m_data stays stable while m_valid=1 and m_ready=0.
- burst_len=5 with the FIFO holding 2 words, then 3 more written 10 cycles later:
  - busy stays high;
  - fifo_rd_en stays low while fifo_empty=1;
  - the burst completes and done pulses once.
- start with burst_len=0:
  - done pulses 1 cycle later;
  - busy never rises;
  - fifo_rd_en stays 0.
- start asserted again during RUN with burst_len=9:
  - the request is ignored;
  - the original len=3 burst completes with exactly 3 reads.
- Reset asserted after 2 of 8 words have been accepted:
  - the next cycle shows m_valid=0, busy=0, done=0 and beats_left=0;
  - a new start with len=2 behaves normally.
